// File: rtl/inst_load_ctrl.sv
// Instruction load controller: collects a high and a low host word into inst_reg,
// issues the instruction to the vector unit and waits for completion.
module inst_load_ctrl #(
    parameter int unsigned BITS    = 8,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BITS-1:0]  byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [BITS-1:0]  ir_data,
    output logic             set_hi,
    output logic             set_lo,
    output logic             exec_start,
    input  logic             exec_done,
    output logic             busy,
    output logic             err_timeout,
    output logic [CNT_W-1:0] inst_count
);

    localparam int unsigned TW     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned T_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [2:0] {
        S_HI     = 3'd0,
        S_LO     = 3'd1,
        S_COMMIT = 3'd2,
        S_ISSUE  = 3'd3,
        S_EXEC   = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [TW-1:0]     timer, timer_n;
    logic [BITS-1:0]   ir_data_n;
    logic [CNT_W-1:0]  count_n;
    logic              set_hi_n, set_lo_n, exec_start_n, err_n, busy_n;
    logic              xfer;

    assign byte_ready = (state == S_HI) || (state == S_LO);
    assign xfer       = byte_valid && byte_ready;

    // Strobes are registered from the transition into the state they belong to.
    always_comb begin
        state_n      = state;
        timer_n      = timer;
        ir_data_n    = ir_data;
        count_n      = inst_count;
        set_hi_n     = 1'b0;
        set_lo_n     = 1'b0;
        exec_start_n = 1'b0;
        err_n        = 1'b0;
        unique case (state)
            S_HI: begin
                if (xfer) begin
                    ir_data_n = byte_in;
                    set_hi_n  = 1'b1;
                    timer_n   = '0;
                    state_n   = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    ir_data_n = byte_in;
                    set_lo_n  = 1'b1;
                    state_n   = S_COMMIT;
                end else if (TIMEOUT != 0) begin
                    if (timer == TW'(T_LAST)) begin
                        err_n   = 1'b1;
                        timer_n = '0;
                        state_n = S_HI;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
            end
            S_COMMIT: begin
                exec_start_n = 1'b1;
                state_n      = S_ISSUE;
            end
            S_ISSUE: begin
                state_n = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    count_n = inst_count + CNT_W'(1);
                    state_n = S_HI;
                end
            end
            default: begin
                state_n = S_HI;
            end
        endcase
        busy_n = (state_n != S_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HI;
            timer       <= '0;
            ir_data     <= '0;
            inst_count  <= '0;
            set_hi      <= 1'b0;
            set_lo      <= 1'b0;
            exec_start  <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            ir_data     <= ir_data_n;
            inst_count  <= count_n;
            set_hi      <= set_hi_n;
            set_lo      <= set_lo_n;
            exec_start  <= exec_start_n;
            err_timeout <= err_n;
            busy        <= busy_n;
        end
    end

endmodule
